// File: rtl/regbank_pkg.sv
// Shared widths, sequencer states and bank direction encodings for the
// register-bank controller.
package regbank_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 2 ** ADDR_W;
    localparam int OP_W   = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    localparam logic RF_READ  = 1'b1;
    localparam logic RF_WRITE = 1'b0;
endpackage

// File: rtl/regbank_ctrl_wb_arb2.sv
// Two-way round-robin writeback arbiter; rr_q names the preferred requester
// and moves to the other one after every grant.
module wb_arb2 (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);
    logic rr_q, rr_d;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        rr_d = rr_q;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = !rr_q;
                gnt1 = rr_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        if (gnt0) rr_d = 1'b1;
        if (gnt1) rr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rr_q <= 1'b0;
        else          rr_q <= rr_d;
    end
endmodule

// File: rtl/regbank_ctrl.sv
// Issue sequencer and writeback arbiter in front of the 8 x 16 register bank,
// with a pending-write scoreboard guarding operand reads.
module regbank_ctrl
    import regbank_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [OP_W-1:0]   iss_opcode,
    input  logic [ADDR_W-1:0] iss_src1,
    input  logic [ADDR_W-1:0] iss_src2,
    input  logic [ADDR_W-1:0] iss_dest,
    input  logic              iss_wr,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [OP_W-1:0]   op_opcode,
    output logic [ADDR_W-1:0] op_dest,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              rf_ce,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_wsel,
    output logic [ADDR_W-1:0] rf_sel1,
    output logic [ADDR_W-1:0] rf_sel2,
    output logic [DATA_W-1:0] rf_din,
    input  logic [DATA_W-1:0] rf_src1,
    input  logic [DATA_W-1:0] rf_src2,
    output logic [NREGS-1:0]  busy_mask
);
    state_t              state_q, state_d;
    logic [NREGS-1:0]    pending_q, pending_d;
    logic [ADDR_W-1:0]   sel1_q, sel1_d, sel2_q, sel2_d;
    logic [OP_W-1:0]     opc_q, opc_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic                op_valid_q, op_valid_d;
    logic [OP_W-1:0]     op_opcode_q, op_opcode_d;
    logic [ADDR_W-1:0]   op_dest_q, op_dest_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic                in_idle, issue_ok;

    assign in_idle = (state_q == S_IDLE);

    wb_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (in_idle),
        .req0    (wb0_valid),
        .req1    (wb1_valid),
        .gnt0    (wb0_ready),
        .gnt1    (wb1_ready)
    );

    // Writes take the cycle whenever any writeback is requested; the issue retries.
    assign issue_ok = in_idle && !(wb0_valid || wb1_valid) && iss_valid && !op_valid_q
                      && !pending_q[iss_src1] && !pending_q[iss_src2]
                      && !(iss_wr && pending_q[iss_dest]);
    assign iss_ready = issue_ok;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        sel1_d      = sel1_q;
        sel2_d      = sel2_q;
        opc_d       = opc_q;
        dst_d       = dst_q;
        op_valid_d  = op_valid_q;
        op_opcode_d = op_opcode_q;
        op_dest_d   = op_dest_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rf_ce       = 1'b0;
        rf_rw       = RF_READ;
        rf_wsel     = '0;
        rf_sel1     = '0;
        rf_sel2     = '0;
        rf_din      = '0;

        if (op_valid_q && op_ready) op_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wb0_ready || wb1_ready) begin
                    rf_ce   = 1'b1;
                    rf_rw   = RF_WRITE;
                    rf_wsel = wb0_ready ? wb0_addr : wb1_addr;
                    rf_din  = wb0_ready ? wb0_data : wb1_data;
                    pending_d[rf_wsel] = 1'b0;
                end else if (issue_ok) begin
                    rf_ce   = 1'b1;
                    rf_sel1 = iss_src1;
                    rf_sel2 = iss_src2;
                    sel1_d  = iss_src1;
                    sel2_d  = iss_src2;
                    opc_d   = iss_opcode;
                    dst_d   = iss_dest;
                    if (iss_wr) pending_d[iss_dest] = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rf_ce       = 1'b1;
                rf_sel1     = sel1_q;
                rf_sel2     = sel2_q;
                op_a_d      = rf_src1;
                op_b_d      = rf_src2;
                op_opcode_d = opc_q;
                op_dest_d   = dst_q;
                op_valid_d  = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            sel1_q      <= '0;
            sel2_q      <= '0;
            opc_q       <= '0;
            dst_q       <= '0;
            op_valid_q  <= 1'b0;
            op_opcode_q <= '0;
            op_dest_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
            opc_q       <= opc_d;
            dst_q       <= dst_d;
            op_valid_q  <= op_valid_d;
            op_opcode_q <= op_opcode_d;
            op_dest_q   <= op_dest_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
        end
    end

    assign op_valid  = op_valid_q;
    assign op_opcode = op_opcode_q;
    assign op_dest   = op_dest_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign busy_mask = pending_q;
endmodule

// File: tb/tb_regbank_ctrl.sv
// Directed bench for regbank_ctrl with a behavioural 8 x 16 register bank.
module tb_regbank_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        iss_valid, iss_ready, iss_wr;
    logic [3:0]  iss_opcode;
    logic [2:0]  iss_src1, iss_src2, iss_dest;
    logic        op_valid, op_ready;
    logic [3:0]  op_opcode;
    logic [2:0]  op_dest;
    logic [15:0] op_a, op_b;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [2:0]  wb0_addr, wb1_addr;
    logic [15:0] wb0_data, wb1_data;
    logic        rf_ce, rf_rw;
    logic [2:0]  rf_wsel, rf_sel1, rf_sel2;
    logic [15:0] rf_din, rf_src1, rf_src2;
    logic [7:0]  busy_mask;

    logic [15:0] mem [8];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    regbank_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dest(iss_dest), .iss_wr(iss_wr),
        .op_valid(op_valid), .op_ready(op_ready), .op_opcode(op_opcode),
        .op_dest(op_dest), .op_a(op_a), .op_b(op_b),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .rf_ce(rf_ce), .rf_rw(rf_rw), .rf_wsel(rf_wsel), .rf_sel1(rf_sel1),
        .rf_sel2(rf_sel2), .rf_din(rf_din), .rf_src1(rf_src1), .rf_src2(rf_src2),
        .busy_mask(busy_mask)
    );

    always @(posedge clk) if (rf_ce && !rf_rw) mem[rf_wsel] <= rf_din;
    assign rf_src1 = (rf_ce && rf_rw) ? mem[rf_sel1] : '0;
    assign rf_src2 = (rf_ce && rf_rw) ? mem[rf_sel2] : '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        reset_n = 1'b0; iss_valid = 0; iss_wr = 0; iss_opcode = 0;
        iss_src1 = 0; iss_src2 = 0; iss_dest = 0; op_ready = 0;
        wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
        wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("rst_ce", rf_ce, 0);
        chk("rst_rw", rf_rw, 1);
        chk("rst_busy", busy_mask, 8'h00);
        chk("rst_opv", op_valid, 0);

        // single write R3 = BEEF via wb0
        wb0_valid = 1; wb0_addr = 3; wb0_data = 16'hBEEF;
        #1;
        chk("w_rdy0", wb0_ready, 1);
        chk("w_ce", rf_ce, 1);
        chk("w_rw", rf_rw, 0);
        chk("w_wsel", rf_wsel, 3);
        chk("w_din", rf_din, 16'hBEEF);
        tick();
        wb0_valid = 0;

        // issue src1=src2=3, dest=5
        iss_valid = 1; iss_src1 = 3; iss_src2 = 3; iss_dest = 5; iss_wr = 1; iss_opcode = 4'hA;
        #1;
        chk("i_rdy", iss_ready, 1);
        chk("i_sel1", rf_sel1, 3);
        tick();
        iss_valid = 0;
        #1;
        chk("rd_opv0", op_valid, 0);
        chk("rd_ce", rf_ce, 1);
        chk("rd_rw", rf_rw, 1);
        chk("rd_sel2", rf_sel2, 3);
        chk("rd_irdy", iss_ready, 0);
        tick();
        chk("i_opv", op_valid, 1);
        chk("i_opa", op_a, 16'hBEEF);
        chk("i_opb", op_b, 16'hBEEF);
        chk("i_dest", op_dest, 5);
        chk("i_opc", op_opcode, 4'hA);
        chk("i_busy", busy_mask, 8'h20);
        op_ready = 1;
        tick();
        op_ready = 0;
        chk("consume", op_valid, 0);

        // RAW hazard on R5
        iss_valid = 1; iss_src1 = 5; iss_src2 = 0; iss_dest = 6; iss_wr = 0; iss_opcode = 4'h1;
        #1;
        chk("raw_stall0", iss_ready, 0);
        tick();
        chk("raw_stall1", iss_ready, 0);
        wb0_valid = 1; wb0_addr = 5; wb0_data = 16'h0042;
        #1;
        chk("raw_wgnt", wb0_ready, 1);
        chk("raw_wwins", iss_ready, 0);
        tick();
        wb0_valid = 0;
        #1;
        chk("raw_busy", busy_mask, 8'h00);
        chk("raw_rel", iss_ready, 1);
        tick();
        iss_valid = 0;
        chk("raw_nowr", busy_mask, 8'h00);
        tick();
        chk("raw_opv", op_valid, 1);
        chk("raw_opa", op_a, 16'h0042);
        chk("raw_opb", op_b, 16'h0000);
        op_ready = 1;
        tick();
        op_ready = 0;

        // wb1 write to a non-pending register; also leaves wb0 preferred
        wb1_valid = 1; wb1_addr = 4; wb1_data = 16'h4444;
        #1;
        chk("np_gnt", wb1_ready, 1);
        tick();
        wb1_valid = 0;
        chk("np_busy", busy_mask, 8'h00);

        // arbitration: both requesters for three cycles
        wb0_valid = 1; wb0_addr = 1; wb0_data = 16'h1111;
        wb1_valid = 1; wb1_addr = 2; wb1_data = 16'h2222;
        #1;
        chk("arb1_g0", wb0_ready, 1);
        chk("arb1_g1", wb1_ready, 0);
        tick();
        chk("arb2_g0", wb0_ready, 0);
        chk("arb2_g1", wb1_ready, 1);
        tick();
        chk("arb3_g0", wb0_ready, 1);
        chk("arb3_g1", wb1_ready, 0);
        tick();
        wb0_valid = 0; wb1_valid = 0;

        // readback R1, R2, left unconsumed for back-pressure
        iss_valid = 1; iss_src1 = 1; iss_src2 = 2; iss_dest = 0; iss_wr = 0; iss_opcode = 4'h2;
        #1;
        chk("rb_rdy", iss_ready, 1);
        tick();
        iss_valid = 0;
        tick();
        chk("rb_opa", op_a, 16'h1111);
        chk("rb_opb", op_b, 16'h2222);

        // back-pressure: second issue stalls while wb1 writes R7
        iss_valid = 1; iss_src1 = 7; iss_src2 = 4; iss_dest = 2; iss_wr = 1; iss_opcode = 4'h3;
        wb1_valid = 1; wb1_addr = 7; wb1_data = 16'h7777;
        #1;
        chk("bp_wgnt", wb1_ready, 1);
        chk("bp_stall0", iss_ready, 0);
        tick();
        wb1_valid = 0;
        #1;
        chk("bp_stall1", iss_ready, 0);
        op_ready = 1;
        #1;
        chk("bp_nocomb", iss_ready, 0);
        tick();
        op_ready = 0;
        #1;
        chk("bp_rel", iss_ready, 1);
        tick();
        iss_valid = 0;
        chk("bp_busy", busy_mask, 8'h04);
        chk("bp_read_ce", rf_ce, 1);

        // async reset in the middle of S_READ
        reset_n = 0;
        #1;
        chk("ar_opv", op_valid, 0);
        chk("ar_busy", busy_mask, 8'h00);
        chk("ar_ce", rf_ce, 0);
        chk("ar_opa", op_a, 16'h0000);
        tick();
        reset_n = 1;
        tick(); tick();
        chk("ar_after_opv", op_valid, 0);
        chk("ar_after_busy", busy_mask, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
